hilo_muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_iter_core.sv | 48 ++++
 rtl/hilo_muldiv_unit.sv | 136 +++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    FIXUP = 2'b10
  } state_t;

  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  // MULT and DIV work on two's-complement operands; the U variants do not.
  function automatic logic is_signed_op(input op_t o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One iteration of the shift-add multiply or the restoring divide, on unsigned magnitudes.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_t              mode,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // NOTE: every output and temporary gets a default first so no path infers a latch.
    next_hi = acc_hi;
    next_lo = acc_lo;
    sum     = '0;
    trial   = '0;
    diff    = '0;
    case (mode)
      OP_DIV, OP_DIVU: begin
        // acc_hi is the partial remainder, acc_lo shifts dividend bits out and quotient bits in.
        trial = {acc_hi, acc_lo[WIDTH-1]};
        diff  = trial[WIDTH-1:0] - operand;
        if (trial >= {1'b0, operand}) begin
          next_hi = diff;
          next_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
          next_hi = trial[WIDTH-1:0];
          next_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
      end
      default: begin
        // {acc_hi, acc_lo} is the product register; the multiplier sits in the low half.
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        next_hi = sum[WIDTH:1];
        next_lo = {sum[0], acc_lo[WIDTH-1:1]};
      end
    endcase
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers and MTHI/MTLO writes.
// Optional MULDIV_FAST_MULT_EN: multiplies bypass CALC with a single-cycle multiplier.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(ITERS);

  state_t           state;
  op_t              op_q;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] a_mag, b_mag, acc_hi, acc_lo;
  logic             sign_a, sign_b;

  op_t              op_in;
  logic             in_sign_a, in_sign_b;
  logic [WIDTH-1:0] in_mag_a, in_mag_b;
  logic [WIDTH-1:0] core_hi, core_lo, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;

  assign op_in     = op_t'(op);
  assign in_sign_a = is_signed_op(op_in) & A[WIDTH-1];
  assign in_sign_b = is_signed_op(op_in) & B[WIDTH-1];
  assign in_mag_a  = in_sign_a ? -A : A;
  assign in_mag_b  = in_sign_b ? -B : B;

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .mode    (op_q),
    .operand ((op_q == OP_DIV || op_q == OP_DIVU) ? b_mag : a_mag),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .next_hi (core_hi),
    .next_lo (core_lo)
  );

  // Sign correction on the unsigned magnitude results.
  always_comb begin
    prod = {acc_hi, acc_lo};
`ifdef MULDIV_FAST_MULT_EN
    prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif
    if (sign_a ^ sign_b) prod = -prod;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    case (op_q)
      OP_DIV, OP_DIVU: begin
        if (b_mag == '0) begin
          fix_lo = DIV0_QUOTIENT;
          fix_hi = sign_a ? -a_mag : a_mag;
        end else begin
          fix_lo = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
          fix_hi = sign_a ? -acc_hi : acc_hi;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= OP_MULT;
      count  <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      HI     <= '0;
      LO     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op_in;
            sign_a <= in_sign_a;
            sign_b <= in_sign_b;
            a_mag  <= in_mag_a;
            b_mag  <= in_mag_b;
            count  <= '0;
            busy   <= 1'b1;
            acc_hi <= '0;
            state  <= CALC;
            if (op_in == OP_DIV || op_in == OP_DIVU) begin
              acc_lo <= in_mag_a;
            end else begin
              acc_lo <= in_mag_b;
`ifdef MULDIV_FAST_MULT_EN
              state  <= FIXUP;
`endif
            end
          end else begin
            if (mthi) HI <= A;
            if (mtlo) LO <= A;
          end
        end
        CALC: begin
          acc_hi <= core_hi;
          acc_lo <= core_lo;
          count  <= count + 1'b1;
          if (count == CNT_W'(ITERS - 1)) state <= FIXUP;
        end
        FIXUP: begin
          HI    <= fix_hi;
          LO    <= fix_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed corner cases plus random ops vs an arithmetic model.
module tb_hilo_muldiv_unit;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;
  localparam int ITERS = 32;
`ifdef MULDIV_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk, rst_n, start, mthi, mtlo, busy, done;
  logic [1:0]  op_r;
  logic [31:0] A, B, HI, LO;

  int vectors = 0;
  int miscompares = 0;

  hilo_muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op_r),
    .A     (A),
    .B     (B),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .HI    (HI),
    .LO    (LO),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference result {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = '0;
    case (o)
      MULT:  res = sa * sb;
      MULTU: res = ua * ub;
      DIV: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {ua[31:0] % ub[31:0], ua[31:0] / ub[31:0]};
      end
    endcase
    return res;
  endfunction

  function automatic int latency(input logic [1:0] o);
    if (FAST && !o[1]) return 1;
    return ITERS + 1;
  endfunction

  // Issue one op, optionally with MTHI/MTLO in the start cycle or with
  // stray start/MTHI/MTLO while busy, then check timing and result.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit with_mt, input bit interfere, input string tag);
    logic [63:0] expv;
    logic [31:0] hi_before, lo_before;
    int cycles, busy_cnt;
    bit got;
    expv = model(o, a, b);
    @(negedge clk);
    hi_before = HI;
    lo_before = LO;
    start = 1'b1; op_r = o; A = a; B = b;
    mthi = with_mt; mtlo = with_mt;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    A = $urandom; B = $urandom; op_r = 2'($urandom);
    check({tag, "/done_low_at_start"}, {31'd0, done}, 32'd1 - 32'd1);
    check({tag, "/busy_at_start"}, {31'd0, busy}, 32'd1);
    if (with_mt) begin
      check({tag, "/start_wins_hi"}, HI, hi_before);
      check({tag, "/start_wins_lo"}, LO, lo_before);
    end
    cycles = 0; busy_cnt = 1; got = 1'b0;
    while (!got && cycles < 200) begin
      if (interfere && cycles == 4) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; A = 32'hDEAD_BEEF; op_r = MULT;
      end
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      cycles++;
      if (done === 1'b1) got = 1'b1;
      else if (busy === 1'b1) busy_cnt++;
    end
    check({tag, "/done"}, {31'd0, done}, 32'd1);
    check({tag, "/latency"}, cycles, latency(o));
    check({tag, "/busy_cycles"}, busy_cnt, latency(o));
    check({tag, "/busy_in_done"}, {31'd0, busy}, 32'd0);
    check({tag, "/HI"}, HI, expv[63:32]);
    check({tag, "/LO"}, LO, expv[31:0]);
  endtask

  initial begin
    logic [31:0] hi_s, lo_s, ra, rb;
    logic [1:0]  ro;
    bit          seen;
    rst_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op_r = 2'b00; A = '0; B = '0;

    // Reset values
    #12;
    check("reset/HI", HI, 32'd0);
    check("reset/LO", LO, 32'd0);
    check("reset/busy", {31'd0, busy}, 32'd0);
    check("reset/done", {31'd0, done}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed corner cases
    run_op(MULT,  32'hFFFF_FFFD, 32'd7,        0, 0, "mult_neg3x7");
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu_max");
    run_op(DIV,   32'hFFFF_FFF9, 32'd2,        0, 0, "div_neg7by2");
    run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_overflow");
    run_op(DIVU,  32'd5,         32'd0,        0, 0, "divu_by0");
    run_op(DIV,   32'hFFFF_FFFB, 32'd0,        0, 0, "div_by0_neg");
    run_op(DIV,   32'd7,         32'hFFFF_FFFE, 0, 0, "div_7byneg2");
    run_op(MULT,  32'h8000_0000, 32'h8000_0000, 0, 0, "mult_minmin");

    // MTHI / MTLO in IDLE
    @(negedge clk); lo_s = LO;
    mthi = 1'b1; A = 32'h0000_1234;
    @(posedge clk); #1; mthi = 1'b0;
    check("mthi/HI", HI, 32'h0000_1234);
    check("mthi/LO_kept", LO, lo_s);
    @(negedge clk); hi_s = HI;
    mtlo = 1'b1; A = 32'h0000_5678;
    @(posedge clk); #1; mtlo = 1'b0;
    check("mtlo/LO", LO, 32'h0000_5678);
    check("mtlo/HI_kept", HI, hi_s);
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; A = 32'hABCD_0001;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
    check("mthilo/HI", HI, 32'hABCD_0001);
    check("mthilo/LO", LO, 32'hABCD_0001);

    // start beats mthi/mtlo; stray writes and starts while busy are ignored
    run_op(MULTU, 32'd3, 32'd9, 1, 0, "start_wins");
    run_op(DIVU, 32'd1000, 32'd7, 0, 1, "divu_busy_ignore");
    // back-to-back issue from the done cycle
    run_op(DIV, 32'hFFFF_FF00, 32'd16, 0, 0, "b2b_1");
    run_op(DIVU, 32'hFFFF_FF00, 32'd16, 0, 0, "b2b_2");

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; op_r = DIV; A = 32'd12345; B = 32'd77;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset/HI", HI, 32'd0);
    check("midreset/LO", LO, 32'd0);
    check("midreset/busy", {31'd0, busy}, 32'd0);
    check("midreset/done", {31'd0, done}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check("midreset/no_done_after", {31'd0, seen}, 32'd0);

    // Random operations
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(ro, ra, rb, 0, 0, $sformatf("rand%0d_op%0d", i, ro));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
